// File: rtl/rng_axi_wr_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between the RNG write engine
// and the memory subsystem.
interface rng_axi_wr_engine_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 16
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/rng_axi_wr_engine.sv
// Streams generator words to consecutive memory addresses as AXI4 INCR
// bursts, split at BURST_BEATS and 4 KB boundaries, with bounded outstanding.
module rng_axi_wr_engine #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 64,
    parameter int ID_W        = 16,
    parameter int BURST_BEATS = 64,
    parameter int MAX_OUTST   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [31:0]         num_beats_i,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [31:0]         beats_written_o,
    output logic                resp_err_o,
    rng_axi_wr_engine_if.master axi
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int LW    = 9;
    localparam int PW    = $clog2(MAX_OUTST);
    localparam int OW    = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rem_aw_q, rem_aw_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       bw_q, bw_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     fifo_q [MAX_OUTST];
    logic              w_act_q, w_act_d;
    logic [LW-1:0]     w_left_q, w_left_d;

    logic [12:0]       bnd_bytes;
    logic [31:0]       bnd_beats;
    logic [31:0]       len32;
    logic [LW-1:0]     len;
    logic              aw_hs, w_hs, b_hs;
    logic              fifo_empty, busy;
    logic              unused_bid;

    // Beats left before the next 4 KB page; a burst may not cross it
    assign bnd_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign bnd_beats = 32'(bnd_bytes >> SZ);

    always_comb begin
        len32 = 32'(BURST_BEATS);
        if (rem_aw_q < len32)
            len32 = rem_aw_q;
        if (bnd_beats < len32)
            len32 = bnd_beats;
    end

    assign len        = LW'(len32);
    assign busy       = (state_q != IDLE);
    assign fifo_empty = (wr_q == rd_q);
    assign unused_bid = ^axi.bid;

    assign axi.awid    = '0;
    assign axi.awsize  = 3'(SZ);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'(len - LW'(1));
    assign axi.awvalid = (state_q == RUN) && (rem_aw_q != 32'd0)
                         && (outst_q != OW'(MAX_OUTST));

    // W is a pure pass-through of the generator stream while a burst is open
    assign axi.wdata  = in_data_i;
    assign axi.wstrb  = '1;
    assign axi.wvalid = w_act_q & in_valid_i;
    assign axi.wlast  = w_act_q && (w_left_q == LW'(1));
    assign axi.bready = busy;
    assign in_ready_o = w_act_q & axi.wready & in_valid_i;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;
    assign b_hs  = axi.bvalid & axi.bready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_aw_d = rem_aw_q;
        num_d    = num_q;
        bw_d     = bw_q;
        err_d    = err_q;
        done_d   = 1'b0;
        wr_d     = wr_q;
        rd_d     = rd_q;
        w_act_d  = w_act_q;
        w_left_d = w_left_q;
        outst_d  = outst_q + OW'(aw_hs) - OW'(b_hs);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    rem_aw_d = num_beats_i;
                    num_d    = num_beats_i;
                    bw_d     = 32'd0;
                    err_d    = 1'b0;
                    if (num_beats_i == 32'd0)
                        done_d = 1'b1;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (rem_aw_q == 32'd0 && bw_q == num_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (aw_hs) begin
            addr_d   = addr_q + (ADDR_W'(len) << SZ);
            rem_aw_d = rem_aw_q - 32'(len);
            wr_d     = wr_q + 1'b1;
        end

        if (w_act_q) begin
            if (w_hs) begin
                bw_d     = bw_q + 32'd1;
                w_left_d = w_left_q - LW'(1);
                if (w_left_q == LW'(1))
                    w_act_d = 1'b0;
            end
        end else if (!fifo_empty) begin
            w_act_d  = 1'b1;
            w_left_d = fifo_q[rd_q[PW-1:0]];
            rd_d     = rd_q + 1'b1;
        end

        if (b_hs && axi.bresp != 2'b00)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (aw_hs)
            fifo_q[wr_q[PW-1:0]] <= len;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_aw_q <= '0;
            num_q    <= '0;
            bw_q     <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            outst_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            w_act_q  <= 1'b0;
            w_left_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_aw_q <= rem_aw_d;
            num_q    <= num_d;
            bw_q     <= bw_d;
            err_q    <= err_d;
            done_q   <= done_d;
            outst_q  <= outst_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            w_act_q  <= w_act_d;
            w_left_q <= w_left_d;
        end
    end

    assign busy_o          = busy;
    assign done_o          = done_q;
    assign beats_written_o = bw_q;
    assign resp_err_o      = err_q;
endmodule

// File: tb/tb_rng_axi_wr_engine.sv
// Bench for rng_axi_wr_engine: AXI slave responder, stream source and a
// burst-list reference model derived from the 4 KB / max-burst rules.
module tb_rng_axi_wr_engine;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   num_beats = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, busy, done, resp_err;
    logic [31:0]   bw;

    rng_axi_wr_engine_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) axi ();

    rng_axi_wr_engine #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW),
        .BURST_BEATS(64), .MAX_OUTST(8)
    ) u_dut (
        .clk(clk), .rst(rst), .start_i(start),
        .base_addr_i(base_addr), .num_beats_i(num_beats),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .busy_o(busy), .done_o(done), .beats_written_o(bw),
        .resp_err_o(resp_err), .axi(axi)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int len; } burst_t;
    typedef struct {
        logic [63:0] base; int n; int naw; int len0; int lenl; int err;
    } vec_t;

    burst_t exp_q[$];
    int obs_len[$];
    int nvec = 0, nfail = 0;
    int aw_rate = 100, w_rate = 100, iv_rate = 100;
    int aw_n, w_n, b_n, b_pend = 0, b_allow = 1 << 30;
    int aw_beats, wb_i, w_in, outst_m = 0, err_idx = -1;
    int cyc = 0, last_aw_cyc = 0, last_b_cyc = 0;
    int done_cnt = 0, d0 = 0, any_valid = 0;
    bit prev_done = 1'b0;
    int unsigned seed = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(int k);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++)
            w[i*32 +: 32] = (32'(k) * 32'h9E3779B1) ^ seed ^ 32'(i);
        return w;
    endfunction

    // Reference burst list: page-bounded, at most 64 beats, 64 B per beat
    function automatic void build_exp(logic [63:0] base, int n);
        logic [63:0] a;
        int rem, room, l;
        a = base;
        rem = n;
        exp_q.delete();
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 64;
            l = rem;
            if (l > 64) l = 64;
            if (l > room) l = room;
            exp_q.push_back('{a, l});
            a += 64'(64 * l);
            rem -= l;
        end
    endfunction

    task automatic monitor();
        bit el;
        cyc++;
        if (axi.awvalid || axi.wvalid) any_valid++;
        if (axi.awvalid) chk("aw_cap", 64'(outst_m < 8), 1);
        if (axi.wvalid || in_ready)
            chk("in_ready", in_ready, axi.wvalid && axi.wready);
        if (busy || axi.bready) chk("bready", axi.bready, busy);
        if (axi.wvalid && axi.wready) begin
            chk("w_after_aw", 64'(w_n < aw_beats), 1);
            chk("wdata", 64'(axi.wdata == word_of(w_n)), 1);
            chk("wstrb", 64'(&axi.wstrb), 1);
            el = (wb_i < exp_q.size()) && (w_in + 1 == exp_q[wb_i].len);
            chk("wlast", axi.wlast, el);
            if (el) begin
                wb_i++; w_in = 0; b_pend++;
            end else w_in++;
            w_n++;
        end
        if (axi.awvalid && axi.awready) begin
            if (aw_n < exp_q.size()) begin
                chk("awaddr", axi.awaddr, exp_q[aw_n].addr);
                chk("awlen", axi.awlen, 64'(exp_q[aw_n].len - 1));
            end else chk("aw_extra", 64'(aw_n), 64'(exp_q.size()));
            chk("awsize", axi.awsize, 6);
            chk("awid", axi.awid, 0);
            obs_len.push_back(int'(axi.awlen));
            aw_beats += int'(axi.awlen) + 1;
            aw_n++; outst_m++; last_aw_cyc = cyc;
        end
        if (axi.bvalid && axi.bready) begin
            b_pend--; b_allow--; b_n++; outst_m--; last_b_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_busy", busy, 0);
            chk("done_width", prev_done, 0);
        end
        prev_done = done;
    endtask

    task automatic drive();
        axi.awready = ($urandom_range(99) < aw_rate);
        axi.wready  = ($urandom_range(99) < w_rate);
        in_valid    = ($urandom_range(99) < iv_rate);
        in_data     = word_of(w_n);
        axi.bvalid  = (b_pend > 0) && (b_allow > 0);
        axi.bresp   = (b_n == err_idx) ? 2'b10 : 2'b00;
        axi.bid     = 16'($urandom);
    endtask

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bresp = 2'b00; axi.bid = '0;
        forever begin
            @(negedge clk); monitor();
            @(posedge clk); #1; drive();
        end
    end

    task automatic start_job(logic [63:0] base, int n, int e);
        build_exp(base, n);
        obs_len.delete();
        aw_n = 0; w_n = 0; b_n = 0; wb_i = 0; w_in = 0; aw_beats = 0;
        any_valid = 0; err_idx = e; seed = $urandom; d0 = done_cnt;
        base_addr = base; num_beats = 32'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int n, bit exp_err);
        for (int c = 0; c < 20000 && done_cnt == d0; c++) @(posedge clk);
        #3;
        chk("done_seen", 64'(done_cnt), 64'(d0 + 1));
        chk("aw_count", 64'(aw_n), 64'(exp_q.size()));
        chk("w_beats", 64'(w_n), 64'(n));
        chk("beats_written", bw, 64'(n));
        chk("resp_err", resp_err, exp_err);
        chk("idle_busy", busy, 0);
    endtask

    vec_t tbl[5];

    initial begin
        int nrand;
        tbl[0] = '{64'h0,    64,  1, 63, 63, -1};
        tbl[1] = '{64'h1000, 130, 3, 63, 1,  -1};
        tbl[2] = '{64'hFC0,  3,   2, 0,  1,  -1};
        tbl[3] = '{64'h1F40, 200, 5, 2,  4,  -1};
        tbl[4] = '{64'h1000, 130, 3, 63, 1,  1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bw", bw, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;

        foreach (tbl[i]) begin
            start_job(tbl[i].base, tbl[i].n, tbl[i].err);
            chk("start_busy", busy, 1);
            chk("start_err_clr", resp_err, 0);
            chk("start_bw_clr", bw, 0);
            wait_done(tbl[i].n, tbl[i].err >= 0);
            chk("tbl_naw", 64'(obs_len.size()), 64'(tbl[i].naw));
            if (obs_len.size() > 0) begin
                chk("tbl_len0", 64'(obs_len[0]), 64'(tbl[i].len0));
                chk("tbl_lenl", 64'(obs_len[$]), 64'(tbl[i].lenl));
            end
        end

        // Zero-length job
        start_job(64'h3000, 0, -1);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        @(posedge clk); #1;
        chk("zero_done_once", done, 0);
        repeat (10) @(posedge clk);
        #3;
        chk("zero_no_axi", 64'(any_valid), 0);

        // Outstanding cap with B held off, gapped input stream
        iv_rate = 60;
        b_allow = 0;
        start_job(64'h0, 640, -1);
        for (int c = 0; c < 2000 && aw_n < 8; c++) @(posedge clk);
        repeat (30) @(posedge clk);
        #3;
        chk("aw_capped", 64'(aw_n), 8);
        chk("awvalid_held", axi.awvalid, 0);
        b_allow = 1;
        for (int c = 0; c < 2000 && aw_n < 9; c++) @(posedge clk);
        #3;
        chk("aw9_issued", 64'(aw_n), 9);
        chk("aw9_latency", 64'(last_aw_cyc - last_b_cyc <= 2), 1);
        b_allow = 1 << 30;
        wait_done(640, 1'b0);

        // Start pulsed mid-job must not disturb the running job
        start_job(64'h5F00, 250, 2);
        repeat (15) @(posedge clk);
        #3;
        base_addr = 64'hDEAD_0000; num_beats = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(250, 1'b1);

        // Reset in the middle of a burst
        iv_rate = 100;
        start_job(64'h2000, 300, -1);
        for (int c = 0; c < 2000 && w_n < 20; c++) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        b_pend = 0; outst_m = 0;
        chk("mrst_awvalid", axi.awvalid, 0);
        chk("mrst_wvalid", axi.wvalid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_bw", bw, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk); #3;
        start_job(64'h7FC0, 70, -1);
        wait_done(70, 1'b0);

        // Randomized jobs against the reference model
        nrand = 8;
        for (int j = 0; j < nrand; j++) begin
            logic [63:0] b;
            int n, e;
            b = (64'($urandom_range(0, 16383)) << 6)
                | (64'($urandom_range(0, 1)) << 40);
            n = $urandom_range(1, 300);
            e = $urandom_range(0, 6) - 1;
            aw_rate = $urandom_range(30, 100);
            w_rate  = $urandom_range(30, 100);
            iv_rate = $urandom_range(30, 100);
            start_job(b, n, e);
            wait_done(n, (e >= 0) && (e < exp_q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/rng_axi_wr_engine.md
Name: rng_axi_wr_engine

Overview:
Write-side memory engine inside rng_top. Consumes the stream of random words from the generator core and writes them to consecutive virtual-memory addresses as AXI4 INCR bursts on the axi_m master channels. It is started through soft-register-driven control inputs and reports status back for softreg readout.

Parameters:
DATA_W, 512, AXI data width in bits; one stream word is one beat
ADDR_W, 64, AXI address width
ID_W, 16, AXI ID width
BURST_BEATS, 64, maximum beats per burst (1..256)
MAX_OUTST, 8, maximum write bursts in flight (AW accepted, B not yet received); power of two

Ports:
clk  in  1  user clock
rst  in  1  synchronous reset, active-low (asserted when rst==0)
start  in  1  one-cycle pulse; begin a job (ignored while busy)
base_addr  in  ADDR_W  job start byte address; DATA_W/8-aligned
num_beats  in  32  job length in beats
in_data  in  DATA_W  random word from generator
in_valid  in  1  in_data valid
in_ready  out  1  word consumed this cycle
awid/awaddr/awlen/awsize/awvalid  out  ID_W/ADDR_W/8/3/1  AXI AW
awready  in  1
wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI W
wready  in  1
bid/bresp/bvalid  in  ID_W/2/1  AXI B
bready  out  1
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
beats_written  out  32  W beats accepted in current/last job
resp_err  out  1  sticky: a non-OKAY bresp was seen during job

Behaviour:
- Reset: awvalid=wvalid=in_ready=0, bready=0, busy=0, done=0, beats_written=0, resp_err=0, burst-length FIFO empty, outstanding count 0; FSM to IDLE. Reset mid-job abandons it; no further AW/W is issued.
- Constants: awid=0, awsize=log2(DATA_W/8), wstrb all ones; bready=1 whenever busy.
- FSM: IDLE -> RUN on start. start with num_beats==0 stays IDLE and pulses done the next cycle. RUN -> DRAIN when all AW and W beats are issued. DRAIN -> IDLE when outstanding==0, with a 1-cycle done pulse in that transition cycle. On start, the block latches base_addr and num_beats, clears beats_written and resp_err, and sets busy the next cycle. busy falls in the same cycle as the done pulse.
- AW issue: burst length L = min(BURST_BEATS, remaining_aw, beats to the next 4 KB boundary). awaddr=cur_addr, awlen=L-1. awvalid/awaddr/awlen hold stable until awready. On handshake: cur_addr+=L*DATA_W/8, remaining_aw-=L, push L into the length FIFO, outstanding+1. No awvalid while outstanding==MAX_OUTST.
- W issue: the W engine pops a length only after the matching AW handshake; W never leads AW. While a burst is active: wvalid=in_valid, wdata=in_data, in_ready=wready&&in_valid. This is a combinational pass-through with no data buffering. wlast=1 on the L-th beat. beats_written increments per W handshake. When no burst is active: wvalid=0, in_ready=0.
- B: each bvalid decrements outstanding. A simultaneous AW handshake and B in the same cycle leaves outstanding unchanged. bresp!=0 sets resp_err. bid is ignored.
- Length FIFO depth MAX_OUTST; it cannot overflow because of the outstanding cap.
- start while busy: ignored; latched values are unchanged.

Test Plan:
- base=0x0, num_beats=64, all ready=1 -> one AW (awaddr=0x0, awlen=63, awsize=6); 64 W beats with wlast only on beat 64; one B; done pulse; beats_written=64; resp_err=0.
- base=0x1000, num_beats=130 -> AWs at 0x1000/len63, 0x2000/len63, 0x3000/len1; wlast after beats 64, 128, 130; done after the 3rd B.
- base=0xFC0, num_beats=3 -> AW 0xFC0/len0 then 0x1000/len1; no burst crosses 4 KB.
- bvalid held 0, num_beats=640, BURST_BEATS=64 -> exactly 8 AWs issued, then awvalid stays 0. Release 1 B -> the 9th AW issues within 2 cycles. in_valid gapped randomly -> data order preserved, no beat lost.
- One B returns bresp=2'b10 -> resp_err=1 through to done. The next start clears it to 0. start pulsed mid-job -> no effect.
- num_beats=0 -> no AXI activity; done 1 cycle after start. Reset asserted (rst=0) mid-burst -> next cycle awvalid=wvalid=busy=0 and beats_written=0.
